ppu_cpu_regif: RTL and testbench

//  CPU-facing register interface of the PPU ($2000-$2007 via cpu_addr[2:0]).

---
 rtl/ppu_pkg.sv | 30 +++
 rtl/ppu_vram_req_fsm.sv | 112 +++++++++++
 rtl/ppu_cpu_regif.sv | 152 +++++++++++++++
 tb/tb_ppu_cpu_regif.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_pkg
//  Description : Shared definitions for the PPU CPU register interface:
//                register index constants ($2000-$2007) and the VRAM
//                request state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

    // Register indices as seen on cpu_addr[2:0]
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_MASK    = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_OAMADDR = 3'd3;
    localparam logic [2:0] REG_OAMDATA = 3'd4;
    localparam logic [2:0] REG_SCROLL  = 3'd5;
    localparam logic [2:0] REG_ADDR    = 3'd6;
    localparam logic [2:0] REG_DATA    = 3'd7;

    // VRAM request sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        INC   = 2'd3
    } regif_state_t;

endpackage
`default_nettype wire

// File: rtl/ppu_vram_req_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_vram_req_fsm
//  Description : PPUDATA ($2007) transaction sequencer. Owns the VRAM
//                address pointer, the read buffer and the request/ack
//                handshake toward VRAM.
//  Ports       : start_wr_i/start_rd_i - one-cycle $2007 write/read requests
//                wdata_i              - data to write (latched on start)
//                addr_inc32_i         - pointer step select (+1 / +32)
//                commit_i/commit_addr_i - $2006 pointer load
//                vram_*               - VRAM request interface
//                rd_buf_o             - PPUDATA read buffer
//                busy_o               - transaction in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module ppu_vram_req_fsm
    import ppu_pkg::*;
#(
    parameter int VRAM_AW = 14,
    parameter int DW      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_wr_i,
    input  logic               start_rd_i,
    input  logic [DW-1:0]      wdata_i,
    input  logic               addr_inc32_i,
    input  logic               commit_i,
    input  logic [VRAM_AW-1:0] commit_addr_i,
    input  logic [DW-1:0]      vram_rdata_i,
    input  logic               vram_ack_i,
    output logic [VRAM_AW-1:0] vram_addr_o,
    output logic [DW-1:0]      vram_wdata_o,
    output logic               vram_we_o,
    output logic               vram_re_o,
    output logic [DW-1:0]      rd_buf_o,
    output logic               busy_o
);

    regif_state_t       state_q, state_d;
    logic [VRAM_AW-1:0] addr_q;
    logic [DW-1:0]      wdata_q;
    logic [DW-1:0]      rd_buf_q;
    logic [VRAM_AW-1:0] w_step;

    assign w_step = addr_inc32_i ? VRAM_AW'(32) : VRAM_AW'(1);

    always_comb begin
        state_d   = state_q;
        vram_we_o = 1'b0;
        vram_re_o = 1'b0;
        case (state_q)
            IDLE: begin
                // Starts arriving while not IDLE are dropped, which is how a
                // $2007 access during a busy transaction gets ignored.
                if (start_wr_i) begin
                    state_d = WRITE;
                end else if (start_rd_i) begin
                    state_d = READ;
                end
            end
            WRITE: begin
                vram_we_o = ~rst;
                if (vram_ack_i) begin
                    state_d = INC;
                end
            end
            READ: begin
                vram_re_o = ~rst;
                if (vram_ack_i) begin
                    state_d = INC;
                end
            end
            INC: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_buf_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && start_wr_i) begin
                wdata_q <= wdata_i;
            end
            if ((state_q == READ) && vram_ack_i) begin
                rd_buf_q <= vram_rdata_i;
            end
            // A pointer load from $2006 overrides a coincident increment.
            if (commit_i) begin
                addr_q <= commit_addr_i;
            end else if (state_q == INC) begin
                addr_q <= addr_q + w_step;
            end
        end
    end

    assign vram_addr_o  = addr_q;
    assign vram_wdata_o = wdata_q;
    assign rd_buf_o     = rd_buf_q;
    assign busy_o       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: rtl/ppu_cpu_regif.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_cpu_regif
//  Description : CPU-facing PPU register interface. Converts multi-cycle
//                chip-select accesses into single-cycle register strobes,
//                owns the shared $2005/$2006 write toggle, the $2006 pointer
//                assembly and the CPU read mux.
//  Ports       : cpu_*            - CPU bus (cs held for a whole access)
//                reg_din_o        - latched write data for the register file
//                *_write_en_o     - one-cycle write strobes
//                write_toggle_o   - shared toggle, pre-write value
//                status_*         - PPUSTATUS value / read strobe
//                oamdata_in_i     - OAM read data
//                vram_*, busy_o   - PPUDATA transaction interface
//  Revision    : 1.0 - initial release
// ============================================================================
module ppu_cpu_regif
    import ppu_pkg::*;
#(
    parameter int VRAM_AW = 14,
    parameter int DW      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_cs_i,
    input  logic               cpu_rw_i,
    input  logic [2:0]         cpu_addr_i,
    input  logic [DW-1:0]      cpu_din_i,
    output logic [DW-1:0]      cpu_dout_o,
    output logic [DW-1:0]      reg_din_o,
    output logic               ctrl_write_en_o,
    output logic               mask_write_en_o,
    output logic               oamaddr_write_en_o,
    output logic               oamdata_write_en_o,
    output logic               scroll_write_en_o,
    output logic               write_toggle_o,
    input  logic [DW-1:0]      status_in_i,
    output logic               status_read_o,
    input  logic [DW-1:0]      oamdata_in_i,
    input  logic               addr_inc32_i,
    output logic [VRAM_AW-1:0] vram_addr_o,
    output logic [DW-1:0]      vram_wdata_o,
    output logic               vram_we_o,
    output logic               vram_re_o,
    input  logic [DW-1:0]      vram_rdata_i,
    input  logic               vram_ack_i,
    output logic               busy_o
);

    localparam int HI_W = VRAM_AW - DW;

    logic            cs_q;
    logic            wr_pend_q;
    logic            rd_pend_q;
    logic [2:0]      acc_addr_q;
    logic [DW-1:0]   reg_din_q;
    logic            toggle_q;
    logic [HI_W-1:0] addr_hi_q;

    logic            w_stb;
    logic            w_wr_scroll;
    logic            w_wr_addr;
    logic            w_rd_status;
    logic            w_commit;
    logic [DW-1:0]   w_rd_buf;

    // One strobe per access: rising edge of chip select. cs_q resets low so
    // a select already asserted out of reset still counts.
    assign w_stb = cpu_cs_i & ~cs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q       <= 1'b0;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            acc_addr_q <= '0;
            reg_din_q  <= '0;
            toggle_q   <= 1'b0;
            addr_hi_q  <= '0;
        end else begin
            cs_q      <= cpu_cs_i;
            wr_pend_q <= w_stb & ~cpu_rw_i;
            rd_pend_q <= w_stb & cpu_rw_i;
            if (w_stb) begin
                acc_addr_q <= cpu_addr_i;
            end
            if (w_stb & ~cpu_rw_i) begin
                reg_din_q <= cpu_din_i;
            end
            // Status read clear takes priority over a toggle flip.
            if (w_rd_status) begin
                toggle_q <= 1'b0;
            end else if (w_wr_scroll | w_wr_addr) begin
                toggle_q <= ~toggle_q;
            end
            if (w_wr_addr & ~toggle_q) begin
                addr_hi_q <= reg_din_q[HI_W-1:0];
            end
        end
    end

    // Decode in the cycle after the strobe, once reg_din holds the data.
    assign ctrl_write_en_o    = wr_pend_q & (acc_addr_q == REG_CTRL);
    assign mask_write_en_o    = wr_pend_q & (acc_addr_q == REG_MASK);
    assign oamaddr_write_en_o = wr_pend_q & (acc_addr_q == REG_OAMADDR);
    assign oamdata_write_en_o = wr_pend_q & (acc_addr_q == REG_OAMDATA);
    assign w_wr_scroll        = wr_pend_q & (acc_addr_q == REG_SCROLL);
    assign w_wr_addr          = wr_pend_q & (acc_addr_q == REG_ADDR);
    assign w_rd_status        = rd_pend_q & (acc_addr_q == REG_STATUS);
    assign w_commit           = w_wr_addr & toggle_q;

    assign scroll_write_en_o  = w_wr_scroll;
    assign status_read_o      = w_rd_status;
    assign write_toggle_o     = toggle_q;
    assign reg_din_o          = reg_din_q;

    always_comb begin
        cpu_dout_o = '0;
        if (cpu_cs_i & cpu_rw_i) begin
            case (cpu_addr_i)
                REG_STATUS:  cpu_dout_o = status_in_i;
                REG_OAMDATA: cpu_dout_o = oamdata_in_i;
                REG_DATA:    cpu_dout_o = w_rd_buf;
                default:     cpu_dout_o = reg_din_q;
            endcase
        end
    end

    ppu_vram_req_fsm #(
        .VRAM_AW (VRAM_AW),
        .DW      (DW)
    ) u_vram_req_fsm (
        .clk           (clk),
        .rst           (rst),
        .start_wr_i    (wr_pend_q & (acc_addr_q == REG_DATA)),
        .start_rd_i    (rd_pend_q & (acc_addr_q == REG_DATA)),
        .wdata_i       (reg_din_q),
        .addr_inc32_i  (addr_inc32_i),
        .commit_i      (w_commit),
        .commit_addr_i ({addr_hi_q, reg_din_q}),
        .vram_rdata_i  (vram_rdata_i),
        .vram_ack_i    (vram_ack_i),
        .vram_addr_o   (vram_addr_o),
        .vram_wdata_o  (vram_wdata_o),
        .vram_we_o     (vram_we_o),
        .vram_re_o     (vram_re_o),
        .rd_buf_o      (w_rd_buf),
        .busy_o        (busy_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_ppu_cpu_regif.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ppu_cpu_regif
//  Description : Directed self-checking bench for ppu_cpu_regif with a
//                simple VRAM responder (programmable ack delay).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_cpu_regif;
    import ppu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_cs, cpu_rw;
    logic [2:0]  cpu_addr;
    logic [7:0]  cpu_din, cpu_dout, reg_din;
    logic        ctrl_we, mask_we, oamaddr_we, oamdata_we, scroll_we;
    logic        write_toggle, status_read;
    logic [7:0]  status_in, oamdata_in;
    logic        addr_inc32;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata, vram_rdata;
    logic        vram_we, vram_re, vram_ack, busy;

    int n_chk  = 0;
    int n_pass = 0;

    // Bench-side state
    int         ack_dly   = 1;
    logic       force_ack = 1'b0;
    logic [7:0] rdq[$];
    int         we_cycles = 0, re_cycles = 0, n_status = 0;
    logic [13:0] we_addr;
    logic [7:0]  we_data;
    logic [4:0]  last_stb, next_stb;
    logic        last_tog;
    logic [7:0]  d;
    int          base;

    ppu_cpu_regif #(.VRAM_AW(14), .DW(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_cs_i           (cpu_cs),
        .cpu_rw_i           (cpu_rw),
        .cpu_addr_i         (cpu_addr),
        .cpu_din_i          (cpu_din),
        .cpu_dout_o         (cpu_dout),
        .reg_din_o          (reg_din),
        .ctrl_write_en_o    (ctrl_we),
        .mask_write_en_o    (mask_we),
        .oamaddr_write_en_o (oamaddr_we),
        .oamdata_write_en_o (oamdata_we),
        .scroll_write_en_o  (scroll_we),
        .write_toggle_o     (write_toggle),
        .status_in_i        (status_in),
        .status_read_o      (status_read),
        .oamdata_in_i       (oamdata_in),
        .addr_inc32_i       (addr_inc32),
        .vram_addr_o        (vram_addr),
        .vram_wdata_o       (vram_wdata),
        .vram_we_o          (vram_we),
        .vram_re_o          (vram_re),
        .vram_rdata_i       (vram_rdata),
        .vram_ack_i         (vram_ack),
        .busy_o             (busy)
    );

    always #5 clk = ~clk;

    // VRAM responder: ack after ack_dly cycles of held request
    initial begin : g_vram_model
        int cnt;
        cnt        = 0;
        vram_ack   = 1'b0;
        vram_rdata = 8'h00;
        forever begin
            @(negedge clk);
            vram_ack = 1'b0;
            if (force_ack) begin
                vram_ack   = 1'b1;
                vram_rdata = 8'hEE;
            end else if (vram_we || vram_re) begin
                cnt++;
                if (cnt >= ack_dly) begin
                    vram_ack = 1'b1;
                    if (vram_re) vram_rdata = (rdq.size() > 0) ? rdq.pop_front() : 8'h00;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Activity monitor
    always @(negedge clk) begin
        if (vram_we) begin
            we_cycles++;
            we_addr = vram_addr;
            we_data = vram_wdata;
        end
        if (vram_re) re_cycles++;
        if (status_read) n_status++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Write access: cs held 3 cycles; strobe vector sampled in the cycle
    // after the strobe edge and again one cycle later.
    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] v);
        @(negedge clk);
        cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_din = v;
        @(negedge clk);
        last_stb = {ctrl_we, mask_we, oamaddr_we, oamdata_we, scroll_we};
        last_tog = write_toggle;
        @(negedge clk);
        next_stb = {ctrl_we, mask_we, oamaddr_we, oamdata_we, scroll_we};
        @(negedge clk);
        cpu_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [7:0] v);
        @(negedge clk);
        cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = a;
        #1 v = cpu_dout;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        cpu_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        rst = 1'b1; cpu_cs = 1'b0; cpu_rw = 1'b1; cpu_addr = 3'd0; cpu_din = 8'h00;
        status_in = 8'h80; oamdata_in = 8'h4C; addr_inc32 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_strobes", {ctrl_we, mask_we, oamaddr_we, oamdata_we, scroll_we, status_read}, 0);
        chk("rst_vram_req", {vram_we, vram_re}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_toggle", write_toggle, 0);
        chk("rst_vram_addr", vram_addr, 0);
        chk("rst_reg_din", reg_din, 0);

        // cs already high at the first post-reset cycle is an access
        cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = REG_CTRL; cpu_din = 8'h5A;
        rst = 1'b0;
        @(negedge clk);
        chk("first_cycle_ctrl_we", ctrl_we, 1);
        chk("first_cycle_reg_din", reg_din, 8'h5A);
        @(negedge clk);
        chk("ctrl_we_one_cycle", ctrl_we, 0);
        cpu_cs = 1'b0;
        @(negedge clk);

        // Strobe decode
        cpu_wr(REG_MASK, 8'h1E);    chk("mask_decode", last_stb, 5'b01000);
        cpu_wr(REG_OAMADDR, 8'h07); chk("oamaddr_decode", last_stb, 5'b00100);
        cpu_wr(REG_OAMDATA, 8'h99); chk("oamdata_decode", last_stb, 5'b00010);

        // 1: scroll toggle sequence
        cpu_wr(REG_SCROLL, 8'h12);
        chk("t1_scroll_stb", last_stb, 5'b00001);
        chk("t1_scroll_one_cycle", next_stb, 5'b00000);
        chk("t1_tog_first", last_tog, 0);
        chk("t1_reg_din", reg_din, 8'h12);
        cpu_wr(REG_SCROLL, 8'h34);
        chk("t1_tog_second", last_tog, 1);
        chk("t1_tog_end", write_toggle, 0);

        // 2: status read clears toggle
        cpu_wr(REG_SCROLL, 8'h12);
        base = n_status;
        cpu_rd(REG_STATUS, d);
        chk("t2_status_dout", d, 8'h80);
        chk("t2_status_pulses", n_status - base, 1);
        chk("t2_tog_cleared", write_toggle, 0);
        cpu_wr(REG_SCROLL, 8'h56);
        chk("t2_tog_after_clear", last_tog, 0);
        cpu_rd(REG_OAMDATA, d);     chk("t2_oam_dout", d, 8'h4C);
        cpu_rd(REG_CTRL, d);        chk("t2_open_bus", d, 8'h56);
        cpu_rd(REG_STATUS, d);      // resync toggle to 0
        chk("t2_tog_resync", write_toggle, 0);

        // 3: PPUADDR then PPUDATA write with ack after 3 cycles
        cpu_wr(REG_ADDR, 8'h7F);
        cpu_wr(REG_ADDR, 8'h10);
        chk("t3_addr_commit", vram_addr, 14'h3F10);
        ack_dly = 3;
        base = we_cycles;
        cpu_wr(REG_DATA, 8'hAB);
        wait_idle("t3_idle");
        chk("t3_we_cycles", we_cycles - base, 3);
        chk("t3_we_addr", we_addr, 14'h3F10);
        chk("t3_we_data", we_data, 8'hAB);
        chk("t3_addr_inc", vram_addr, 14'h3F11);

        // 4: +32 wraps at 14 bits
        ack_dly = 1;
        addr_inc32 = 1'b1;
        cpu_wr(REG_ADDR, 8'h3F);
        cpu_wr(REG_ADDR, 8'hF0);
        cpu_wr(REG_DATA, 8'h11);
        wait_idle("t4_idle");
        chk("t4_wrap", vram_addr, 14'h0010);
        addr_inc32 = 1'b0;

        // 5: buffered reads
        cpu_wr(REG_ADDR, 8'h20);
        cpu_wr(REG_ADDR, 8'h00);
        rdq.push_back(8'hC1); rdq.push_back(8'hC2); rdq.push_back(8'hC3);
        cpu_rd(REG_DATA, d);  chk("t5_read1", d, 8'h00);
        wait_idle("t5_idle1");
        cpu_rd(REG_DATA, d);  chk("t5_read2", d, 8'hC1);
        wait_idle("t5_idle2");
        chk("t5_addr", vram_addr, 14'h2002);
        ack_dly = 14;
        base = re_cycles;
        cpu_rd(REG_DATA, d);  chk("t5_read3_buf", d, 8'hC2);
        cpu_rd(REG_DATA, d);  chk("t5_busy_read_buf", d, 8'hC2);
        chk("t5_busy", busy, 1);
        cpu_wr(REG_SCROLL, 8'h99);
        chk("t5_scroll_while_busy", last_stb, 5'b00001);
        wait_idle("t5_idle3");
        chk("t5_re_cycles", re_cycles - base, 14);
        chk("t5_busy_read_no_inc", vram_addr, 14'h2003);

        // 6: reset mid-transaction
        ack_dly = 40;
        rdq.delete();
        rdq.push_back(8'hD1);
        cpu_rd(REG_DATA, d);  chk("t6_buf_before", d, 8'hC3);
        @(negedge clk);
        chk("t6_re_held", vram_re, 1);
        rst = 1'b1;
        #1 chk("t6_re_drop_same_cycle", vram_re, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_re_after_rst", vram_re, 0);
        chk("t6_busy_after_rst", busy, 0);
        chk("t6_addr_after_rst", vram_addr, 0);
        force_ack = 1'b1;
        @(negedge clk);
        #1 force_ack = 1'b0;
        @(negedge clk);
        #1 chk("t6_late_ack_busy", busy, 0);
        rdq.delete();
        ack_dly = 1;
        cpu_rd(REG_DATA, d);  chk("t6_buf_cleared", d, 8'h00);
        wait_idle("t6_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
